reg_file_wb_arbiter: RTL

//  Shares the single register-file write port between the ALU/immediate writeback path and the

---
 rtl/reg_file_wb_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reg_file_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb_arbiter
// Purpose  : Register-file write-port arbiter. Load returns always win; ALU
//            and immediate results wait in a small in-order FIFO.
// Revision : 1.0
// ============================================================================
module reg_file_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         w_alu_valid,
    input  logic                         w_alu_op,
    input  logic [ADDR_W-1:0]            w_alu_rd,
    input  logic [DATA_W-1:0]            w_alu_data,
    output logic                         w_alu_ready,
    input  logic                         w_ld_valid,
    input  logic                         w_ld_byte,
    input  logic [ADDR_W-1:0]            w_ld_rd,
    input  logic [DATA_W-1:0]            w_ld_data,
    output logic                         w_rf_we,
    output logic [ADDR_W-1:0]            w_rf_waddr,
    output logic [DATA_W-1:0]            w_rf_wdata,
    output logic [1:0]                   w_wdata_sel,
    output logic [(1<<ADDR_W)-1:0]       w_pend_mask,
    output logic [$clog2(DEPTH+1)-1:0]   w_fifo_count
);
    localparam int c_NREG  = 1 << ADDR_W;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DEPTH-1:0]   r_slot_vld;
    logic [ADDR_W-1:0]  r_fifo_rd   [DEPTH];
    logic [DATA_W-1:0]  r_fifo_data [DEPTH];
    logic               r_fifo_op   [DEPTH];

    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [1:0]         r_sel;
    logic [c_NREG-1:0]  r_pend_mask;

    logic               w_fifo_empty;
    logic               w_alu_acc;
    logic               w_ld_eff;
    logic               w_pop;
    logic               w_push;
    logic               w_bypass;
    logic [DATA_W-1:0]  w_byte_ext;

    logic [c_CNT_W-1:0] w_count_nxt;
    logic [DEPTH-1:0]   w_slot_vld_nxt;
    logic [ADDR_W-1:0]  w_rd_nxt [DEPTH];
    logic [c_NREG-1:0]  w_pend_nxt;

    logic               w_we_nxt;
    logic [ADDR_W-1:0]  w_waddr_nxt;
    logic [DATA_W-1:0]  w_wdata_nxt;
    logic [1:0]         w_sel_nxt;

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Ready is based on the registered count only; a same-cycle pop gives no credit.
    assign w_fifo_empty = (r_count == '0);
    assign w_alu_ready  = (r_count < c_CNT_W'(DEPTH));
    assign w_alu_acc    = w_alu_valid && w_alu_ready && (w_alu_rd != '0);
    assign w_ld_eff     = w_ld_valid && (w_ld_rd != '0);
    assign w_pop        = !w_ld_eff && !w_fifo_empty;
    assign w_bypass     = !w_ld_eff && w_fifo_empty && w_alu_acc;
    assign w_push       = w_alu_acc && (w_ld_eff || !w_fifo_empty);
    assign w_byte_ext   = DATA_W'(signed'(w_ld_data[7:0]));

    // FIFO occupancy after this cycle's push/pop, used for the pending mask.
    always_comb begin
        w_slot_vld_nxt = r_slot_vld;
        w_count_nxt    = r_count;
        for (int i = 0; i < DEPTH; i++) begin
            w_rd_nxt[i] = r_fifo_rd[i];
        end
        if (w_pop) begin
            w_slot_vld_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_slot_vld_nxt[r_wr_ptr] = 1'b1;
            w_rd_nxt[r_wr_ptr]       = w_alu_rd;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        w_pend_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_vld_nxt[i]) begin
                w_pend_nxt[w_rd_nxt[i]] = 1'b1;
            end
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_sel_nxt   = r_sel;
        if (w_ld_eff) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_ld_rd;
            w_wdata_nxt = w_ld_byte ? w_byte_ext : w_ld_data;
            w_sel_nxt   = {1'b0, w_ld_byte};
        end else if (w_pop) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_fifo_rd[r_rd_ptr];
            w_wdata_nxt = r_fifo_data[r_rd_ptr];
            w_sel_nxt   = {1'b1, r_fifo_op[r_rd_ptr]};
        end else if (w_bypass) begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = w_alu_rd;
            w_wdata_nxt = w_alu_data;
            w_sel_nxt   = {1'b1, w_alu_op};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_slot_vld  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_pend_mask <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            if (w_push) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            r_count     <= w_count_nxt;
            r_slot_vld  <= w_slot_vld_nxt;
            r_we        <= w_we_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_sel       <= w_sel_nxt;
            r_pend_mask <= w_pend_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= w_alu_rd;
            r_fifo_data[r_wr_ptr] <= w_alu_data;
            r_fifo_op[r_wr_ptr]   <= w_alu_op;
        end
    end

    assign w_rf_we      = r_we;
    assign w_rf_waddr   = r_waddr;
    assign w_rf_wdata   = r_wdata;
    assign w_wdata_sel  = r_sel;
    assign w_pend_mask  = r_pend_mask;
    assign w_fifo_count = r_count;

endmodule
`default_nettype wire
